cpu_muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the Ghyston CPU family.
- Replaces the single-shot 32x32 multiply multi-cycle-path hack with an explicit multi-cycle engine.
- Sits beside the ALU in pipe stage 1. The pipeline holds its stage-1 registers while o_busy is high, then writes o_result and the flags in the cycle o_done is high.
- Supports low/high multiply and quotient/remainder, signed or unsigned, at a configurable number of bits retired per cycle.

---
 rtl/cpu_muldiv_iter.sv | 194 +++++++++++++++++++
 tb/tb_cpu_muldiv_iter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_muldiv_iter.sv
// cpu_muldiv_iter: iterative multiply/divide unit, retiring BPC bits per enabled cycle.
// Sequence: IDLE -> RUN (WIDTH/BPC cycles) -> FIX (sign fix-up, word select) -> DONE -> IDLE.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clk_en         global clock enable; nothing advances while low
//   i_start          request, accepted only in IDLE
//   i_op             00 MUL low, 01 MULH high, 10 DIV quotient, 11 REM remainder
//   i_signed         1 = two's-complement operands
//   i_a, i_b         multiplicand/dividend, multiplier/divisor
//   o_busy           high from the accepting edge through the o_done cycle
//   o_done           one enabled-cycle pulse, o_result valid
//   o_result         selected result, held until the next accepted start
//   o_z, o_s         result zero / result sign
//   o_divz           last DIV/REM had a zero divisor
// WIDTH must be a multiple of BPC and >= 8; BPC is 1, 2 or 4.
module cpu_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_z,
  output logic             o_s,
  output logic             o_divz
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e r_state, w_state_next;

  logic [1:0]       r_op;
  logic             r_neg_q;   // negate product / quotient in FIX
  logic             r_neg_r;   // negate remainder in FIX
  logic             r_b_zero;
  logic [WIDTH-1:0] r_opa;     // |a|: multiplicand
  logic [WIDTH-1:0] r_opb;     // |b|: divisor
  logic [WIDTH:0]   r_hi;      // product high word / partial remainder
  logic [WIDTH-1:0] r_lo;      // multiplier being consumed / dividend-then-quotient
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_divz;

  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  logic [WIDTH+BPC-1:0] w_pp, w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_rem;
  logic [WIDTH-1:0]     w_div_quo;
  logic [WIDTH:0]       w_hi_next;
  logic [WIDTH-1:0]     w_lo_next;

  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_result;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else if (i_clk_en) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (r_cnt == CW'(1)) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    w_neg_a = i_signed & i_a[WIDTH-1];
    w_neg_b = i_signed & i_b[WIDTH-1];
    w_abs_a = w_neg_a ? -i_a : i_a;
    w_abs_b = w_neg_b ? -i_b : i_b;
  end

  // ---------------- one iteration ----------------
  // Multiply: add digit*multiplicand into the high word, then shift the whole
  // accumulator right by BPC; the sum cannot exceed WIDTH+BPC bits.
  always_comb begin
    w_pp       = {{BPC{1'b0}}, r_opa} * {{WIDTH{1'b0}}, r_lo[BPC-1:0]};
    w_sum      = {{BPC{1'b0}}, r_hi[WIDTH-1:0]} + w_pp;
    w_mul_next = {w_sum, r_lo[WIDTH-1:BPC]};
  end

  // Divide: BPC restoring steps; dividend bits shift out of r_lo while quotient
  // bits shift in.
  always_comb begin
    w_div_rem = r_hi;
    w_div_quo = r_lo;
    for (int i = 0; i < int'(BPC); i++) begin
      w_div_rem = {w_div_rem[WIDTH-1:0], w_div_quo[WIDTH-1]};
      w_div_quo = {w_div_quo[WIDTH-2:0], 1'b0};
      if (w_div_rem >= {1'b0, r_opb}) begin
        w_div_rem    = w_div_rem - {1'b0, r_opb};
        w_div_quo[0] = 1'b1;
      end
    end
  end

  always_comb begin
    w_hi_next = r_op[1] ? w_div_rem : {1'b0, w_mul_next[2*WIDTH-1:WIDTH]};
    w_lo_next = r_op[1] ? w_div_quo : w_mul_next[WIDTH-1:0];
  end

  // ---------------- fix-up and word select ----------------
  // With a zero divisor the restoring loop leaves |a| as remainder, so the
  // remainder sign fix already returns a unchanged; only the quotient needs
  // forcing to all-ones. MIN / -1 falls out naturally as MIN rem 0.
  always_comb begin
    w_prod     = {r_hi[WIDTH-1:0], r_lo};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo_fix  = r_neg_q ? -r_lo : r_lo;
    w_rem_fix  = r_neg_r ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
    w_result   = '0;
    unique case (r_op)
      2'b00: w_result = w_prod_fix[WIDTH-1:0];
      2'b01: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
      2'b10: w_result = r_b_zero ? '1 : w_quo_fix;
      2'b11: w_result = w_rem_fix;
      default: w_result = '0;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= 2'b00;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_divz   <= 1'b0;
    end else if (i_clk_en) begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_op     <= i_op;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_b_zero <= (i_b == '0);
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_hi     <= '0;
            r_lo     <= i_op[1] ? w_abs_a : w_abs_b;
            r_cnt    <= CW'(N);
          end
        end
        StRun: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt - CW'(1);
        end
        StFix: begin
          r_result <= w_result;
          r_divz   <= r_op[1] & r_b_zero;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != StIdle);
  assign o_done   = (r_state == StDone);
  assign o_result = r_result;
  assign o_z      = (r_result == '0);
  assign o_s      = r_result[WIDTH-1];
  assign o_divz   = r_divz;

endmodule

// File: tb/tb_cpu_muldiv_iter.sv
// Directed bench for cpu_muldiv_iter: one BPC=1 instance and one BPC=4 instance.
module tb_cpu_muldiv_iter;

  logic        clk;
  logic        rst, clk_en, start, start4, sgn;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, z, s, divz;
  logic [31:0] result;
  logic        busy4, done4, z4, s4, divz4;
  logic [31:0] result4;

  int total = 0;
  int bad   = 0;
  int cyc;
  int ndone;

  cpu_muldiv_iter #(.WIDTH(32), .BPC(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_start(start), .i_op(op),
    .i_signed(sgn), .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
    .o_result(result), .o_z(z), .o_s(s), .o_divz(divz)
  );

  cpu_muldiv_iter #(.WIDTH(32), .BPC(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_start(start4), .i_op(op),
    .i_signed(sgn), .i_a(a), .i_b(b), .o_busy(busy4), .o_done(done4),
    .o_result(result4), .o_z(z4), .o_s(s4), .o_divz(divz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4 && (busy || busy4); k++) tick();
  endtask

  // Issue one request and return in the o_done cycle; cyc counts busy cycles
  // including the done cycle (200 means the bound expired).
  task automatic run_op(input bit sel4, input logic [1:0] o, input logic sg,
                        input logic [31:0] va, input logic [31:0] vb, output int c);
    wait_idle();
    op = o; sgn = sg; a = va; b = vb;
    if (sel4) start4 = 1'b1;
    else start = 1'b1;
    tick();
    start = 1'b0; start4 = 1'b0;
    c = 1;
    while (!(sel4 ? done4 : done) && c < 200) begin
      tick();
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; start4 = 1'b0;
    sgn = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) tick();
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", result,      32'd0);
    chk("rst_z",      32'(z),      32'd1);
    chk("rst_s",      32'(s),      32'd0);
    chk("rst_divz",   32'(divz),   32'd0);
    rst = 1'b0;
    tick();

    // Unsigned MUL 7*6, both radices
    run_op(1'b0, 2'b00, 1'b0, 32'd7, 32'd6, cyc);
    chk("mul_cycles",  32'(cyc),  32'd34);
    chk("mul_result",  result,    32'h0000002A);
    chk("mul_z",       32'(z),    32'd0);
    chk("mul_busy_in_done", 32'(busy), 32'd1);
    run_op(1'b1, 2'b00, 1'b0, 32'd7, 32'd6, cyc);
    chk("mul4_cycles", 32'(cyc),  32'd10);
    chk("mul4_result", result4,   32'h0000002A);

    // MULH signed and unsigned
    run_op(1'b0, 2'b01, 1'b1, 32'hFFFFFFFE, 32'd3, cyc);
    chk("mulh_s_result", result,  32'hFFFFFFFF);
    chk("mulh_s_sign",   32'(s),  32'd1);
    run_op(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    chk("mulh_u_result", result,  32'hFFFFFFFE);
    run_op(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    chk("mul_u_lo",      result,  32'h00000001);
    run_op(1'b1, 2'b01, 1'b1, 32'hFFFFFFFE, 32'd3, cyc);
    chk("mulh4_s_result", result4, 32'hFFFFFFFF);

    // Unsigned DIV/REM
    run_op(1'b0, 2'b10, 1'b0, 32'd100, 32'd7, cyc);
    chk("divu_result", result,    32'd14);
    chk("divu_cycles", 32'(cyc),  32'd34);
    run_op(1'b0, 2'b11, 1'b0, 32'd100, 32'd7, cyc);
    chk("remu_result", result,    32'd2);
    run_op(1'b1, 2'b10, 1'b0, 32'd100, 32'd7, cyc);
    chk("div4_result", result4,   32'd14);

    // Signed DIV/REM -100/7
    run_op(1'b0, 2'b10, 1'b1, 32'hFFFFFF9C, 32'd7, cyc);
    chk("divs_result", result,    32'hFFFFFFF2);
    run_op(1'b0, 2'b11, 1'b1, 32'hFFFFFF9C, 32'd7, cyc);
    chk("rems_result", result,    32'hFFFFFFFE);
    chk("rems_sign",   32'(s),    32'd1);

    // Divide by zero, then clear by MUL
    run_op(1'b0, 2'b10, 1'b0, 32'd5, 32'd0, cyc);
    chk("divz_result", result,    32'hFFFFFFFF);
    chk("divz_flag",   32'(divz), 32'd1);
    chk("divz_cycles", 32'(cyc),  32'd34);
    run_op(1'b0, 2'b11, 1'b1, 32'hFFFFFFF6, 32'd0, cyc);
    chk("remz_result", result,    32'hFFFFFFF6);
    chk("remz_flag",   32'(divz), 32'd1);
    run_op(1'b0, 2'b00, 1'b0, 32'd7, 32'd6, cyc);
    chk("divz_cleared", 32'(divz), 32'd0);

    // MIN / -1
    run_op(1'b0, 2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("ovf_div",  result,    32'h80000000);
    chk("ovf_divz", 32'(divz), 32'd0);
    run_op(1'b0, 2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("ovf_rem",   result, 32'd0);
    chk("ovf_rem_z", 32'(z), 32'd1);

    // Clock enable low for 5 cycles mid-RUN, then done stretch
    wait_idle();
    op = 2'b00; sgn = 1'b0; a = 32'd123; b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    repeat (9) begin tick(); cyc++; end
    clk_en = 1'b0;
    repeat (5) begin tick(); cyc++; end
    clk_en = 1'b1;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("clken_cycles", 32'(cyc), 32'd39);
    chk("clken_result", result,   32'h0000DB18);
    clk_en = 1'b0;
    repeat (3) tick();
    chk("done_stretch", 32'(done), 32'd1);
    clk_en = 1'b1;
    tick();
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);

    // Start while busy is ignored, including in the DONE cycle
    op = 2'b00; sgn = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    op = 2'b10; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    cyc++;
    start = 1'b0; a = '0; b = '0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("busy_start_cycles", 32'(cyc), 32'd34);
    chk("busy_start_result", result,   32'd15);
    op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 32'd0);

    // Reset mid-RUN
    op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_result", result,    32'd0);
    chk("midrst_z",      32'(z),    32'd1);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
